dec_onehot_seq: RTL and testbench
=================================

// Module: dec_onehot_seq
// PURPOSE
//  Parametrised N-to-2^N one-hot decoder with registered outputs and three modes:
//  direct decode, self-stepping scan, and hold. Drives one-hot selects (mux, LED,
//  row/column strobes) from a binary index or from an internal stepping counter.
//  Single clock domain; sits between control logic and the select lines it drives.
// PARAMETERS
//  SEL_W      2  width of binary select/index; output width OUT_W = 2**SEL_W (localparam)
//  DWELL_W    4  width of scan dwell count (cycles held per output in SCAN)
//  ACTIVE_LOW 0  1: y is inverted (active bit 0, inactive bits 1)
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        synchronous reset, active-high
//  en     in   1        block enable; 0 -> outputs inactive, internal state held
//  mode   in   2        00 OFF, 01 DIRECT, 10 SCAN, 11 HOLD
//  sel    in   SEL_W    DIRECT: index to decode; SCAN: start index on entry/load
//  dwell  in   DWELL_W  SCAN: extra cycles per index (0 = advance every cycle)
//  load   in   1        SCAN: restart scan from sel with fresh dwell count
//  y      out  OUT_W    registered one-hot output (polarity per ACTIVE_LOW)
//  idx    out  SEL_W    registered binary index of active bit
//  valid  out  1        1 when exactly one y bit is active
//  wrap   out  1        1-cycle pulse when SCAN steps from OUT_W-1 to 0
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): y all inactive (0s, or 1s if ACTIVE_LOW), idx=0,
//    valid=0, wrap=0, dwell counter cnt=0, prev-mode register=OFF. rst overrides all.
//  - All outputs registered; inputs sampled at edge N appear on outputs after edge N.
//  - valid=1 <=> exactly one active bit in y, at position idx; valid=0 <=> none active.
//  - en=0: y inactive, valid=0, wrap=0; idx, cnt, prev-mode held. On en returning
//    to 1, operation resumes per mode without re-entry (SCAN continues from held idx/cnt).
//  - OFF: y inactive, valid=0, wrap=0; idx held.
//  - DIRECT: idx<=sel, y<=onehot(sel), valid<=1 every cycle; latency 1 clk. load ignored.
//  - SCAN entry (prev mode != SCAN) or load=1: idx<=sel, cnt<=dwell, valid<=1, wrap<=0.
//  - SCAN steady: if cnt!=0: cnt<=cnt-1, idx held. If cnt==0: idx<=idx+1 (mod OUT_W),
//    cnt<=dwell (dwell sampled that cycle), wrap<=1 iff idx was OUT_W-1.
//    Each index is thus active for dwell+1 cycles.
//  - load and step in same cycle: load wins, no step, wrap=0.
//  - HOLD: y, idx, valid, cnt held; wrap=0. HOLD->SCAN counts as SCAN entry (restart).
//  - Mode changes take effect at the edge they are sampled; no glitch states in y.
//  - Arithmetic: idx increment wraps naturally in SEL_W bits; cnt is unsigned DWELL_W.
//  - dwell changed mid-dwell: affects only the next reload.
// TESTING (SEL_W=2, DWELL_W=4, ACTIVE_LOW=0 unless noted)
//  1 rst=1 two cycles, then release, mode=OFF -> y=0000, idx=0, valid=0, wrap=0.
//  2 DIRECT, en=1, sel=0,1,2,3 on successive cycles -> y=0001,0010,0100,1000 one
//    cycle later each, valid=1.
//  3 SCAN, sel=2, dwell=1 -> y=0100 x2, 1000 x2, 0001 x2 (wrap=1 first cycle of 0001), 0010.
//  4 SCAN dwell=0, load=1 with sel=1 while idx=3 -> next y=0010, wrap=0, then 0100.
//  5 SCAN, en=0 for 3 cycles mid-dwell -> y=0000, valid=0; en=1 resumes same idx/cnt.
//  6 ACTIVE_LOW=1, DIRECT sel=2 -> y=1011; rst mid-SCAN -> y=1111, idx=0, valid=0.

Source files
------------

// File: rtl/dec_onehot_seq_if.sv
// dec_onehot_seq_if : control inputs and decoded select outputs of dec_onehot_seq.
// Rev 1.0
`default_nettype none

interface dec_onehot_seq_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 2**SEL_W;

  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic               load;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  modport master (
    output en, mode, sel, dwell, load,
    input  y, idx, valid, wrap
  );

  modport slave (
    input  en, mode, sel, dwell, load,
    output y, idx, valid, wrap
  );
endinterface

`default_nettype wire

// File: rtl/dec_onehot_seq.sv
// ----------------------------------------------------------------------------
// dec_onehot_seq : registered N-to-2^N one-hot decoder with direct/scan/hold modes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dec_onehot_seq #(
  parameter int SEL_W      = 2,
  parameter int DWELL_W    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dec_onehot_seq_if.slave   bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0]   C_POL     = {OUT_W{(ACTIVE_LOW != 0)}};
  localparam logic [DWELL_W-1:0] C_CNT_ONE = DWELL_W'(1);
  localparam logic [SEL_W-1:0]   C_IDX_ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0]   C_IDX_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_DIRECT = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e              r_prev, w_prev_nxt;
  logic [OUT_W-1:0]   r_y, w_y_nxt;
  logic [SEL_W-1:0]   r_idx, w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_wrap, w_wrap_nxt;
  mode_e              w_mode;

  assign w_mode = mode_e'(bus.mode);

  function automatic logic [OUT_W-1:0] f_onehot(input logic [SEL_W-1:0] i_sel);
    logic [OUT_W-1:0] v_dec;
    v_dec        = '0;
    v_dec[i_sel] = 1'b1;
    return v_dec;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= C_POL;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_prev  <= MODE_OFF;
    end else begin
      r_y     <= w_y_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_prev  <= w_prev_nxt;
    end
  end

  always_comb begin
    w_y_nxt     = r_y;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_prev_nxt  = r_prev;

    if (!bus.en) begin
      // Disabled: blank the outputs but keep idx/cnt/prev so SCAN resumes in place.
      w_y_nxt     = C_POL;
      w_valid_nxt = 1'b0;
    end else begin
      w_prev_nxt = w_mode;
      case (w_mode)
        MODE_OFF: begin
          w_y_nxt     = C_POL;
          w_valid_nxt = 1'b0;
        end
        MODE_DIRECT: begin
          w_idx_nxt   = bus.sel;
          w_y_nxt     = f_onehot(bus.sel) ^ C_POL;
          w_valid_nxt = 1'b1;
        end
        MODE_SCAN: begin
          // Entry (incl. from HOLD) and load both restart; load also pre-empts a step.
          if ((r_prev != MODE_SCAN) || bus.load) begin
            w_idx_nxt = bus.sel;
            w_cnt_nxt = bus.dwell;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end else begin
            w_idx_nxt  = r_idx + C_IDX_ONE;
            w_cnt_nxt  = bus.dwell;
            w_wrap_nxt = (r_idx == C_IDX_MAX);
          end
          w_y_nxt     = f_onehot(w_idx_nxt) ^ C_POL;
          w_valid_nxt = 1'b1;
        end
        MODE_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.y     = r_y;
  assign bus.idx   = r_idx;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_dec_onehot_seq.sv
// tb_dec_onehot_seq : scoreboard bench for dec_onehot_seq, active-high and active-low instances.
// Rev 1.0
`default_nettype none

module tb_dec_onehot_seq;
  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] idx;
    logic       valid;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_onehot_seq_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();
  dec_onehot_seq_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus_al ();

  assign bus_al.en    = bus.en;
  assign bus_al.mode  = bus.mode;
  assign bus_al.sel   = bus.sel;
  assign bus_al.dwell = bus.dwell;
  assign bus_al.load  = bus.load;

  dec_onehot_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_LOW(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  dec_onehot_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACTIVE_LOW(1)) u_dut_al (
    .clk (clk),
    .rst (rst),
    .bus (bus_al.slave)
  );

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q_exp[$];

  logic [3:0] m_y;
  logic [1:0] m_idx;
  logic       m_valid;
  logic       m_wrap;
  logic [3:0] m_cnt;
  logic [1:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference behaviour, evaluated on the values present before the edge.
  task automatic model(input logic i_rst, input logic i_en, input logic [1:0] i_mode,
                       input logic [1:0] i_sel, input logic [3:0] i_dwell, input logic i_load);
    if (i_rst) begin
      m_y = 4'b0000; m_idx = 2'd0; m_valid = 1'b0; m_wrap = 1'b0; m_cnt = 4'd0; m_prev = 2'd0;
    end else if (!i_en) begin
      m_y = 4'b0000; m_valid = 1'b0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      case (i_mode)
        2'd0: begin m_y = 4'b0000; m_valid = 1'b0; end
        2'd1: begin m_idx = i_sel; m_y = 4'b0001 << i_sel; m_valid = 1'b1; end
        2'd2: begin
          if (m_prev != 2'd2 || i_load) begin
            m_idx = i_sel; m_cnt = i_dwell;
          end else if (m_cnt > 4'd0) begin
            m_cnt = m_cnt - 4'd1;
          end else begin
            m_wrap = (m_idx == 2'd3);
            m_idx  = m_idx + 2'd1;
            m_cnt  = i_dwell;
          end
          m_y = 4'b0001 << m_idx; m_valid = 1'b1;
        end
        default: begin end
      endcase
      m_prev = i_mode;
    end
  endtask

  task automatic step(input logic i_rst, input logic i_en, input logic [1:0] i_mode,
                      input logic [1:0] i_sel, input logic [3:0] i_dwell, input logic i_load);
    exp_t       e;
    logic [3:0] inv;
    rst = i_rst; bus.en = i_en; bus.mode = i_mode; bus.sel = i_sel;
    bus.dwell = i_dwell; bus.load = i_load;
    model(i_rst, i_en, i_mode, i_sel, i_dwell, i_load);
    q_exp.push_back('{y: m_y, idx: m_idx, valid: m_valid, wrap: m_wrap});
    @(posedge clk);
    #1;
    e   = q_exp.pop_front();
    inv = ~e.y;
    chk("y",      32'(bus.y),        32'(e.y));
    chk("idx",    32'(bus.idx),      32'(e.idx));
    chk("valid",  32'(bus.valid),    32'(e.valid));
    chk("wrap",   32'(bus.wrap),     32'(e.wrap));
    chk("y_al",   32'(bus_al.y),     32'(inv));
    chk("idx_al", 32'(bus_al.idx),   32'(e.idx));
    chk("val_al", 32'(bus_al.valid), 32'(e.valid));
  endtask

  localparam logic [3:0] C_T3_Y [7] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
  localparam logic       C_T3_W [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [3:0] v_exp;
    rst = 1'b1; bus.en = 1'b0; bus.mode = 2'd0; bus.sel = 2'd0; bus.dwell = 4'd0; bus.load = 1'b0;
    m_y = 4'b0000; m_idx = 2'd0; m_valid = 1'b0; m_wrap = 1'b0; m_cnt = 4'd0; m_prev = 2'd0;

    // Reset then OFF
    step(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
    chk("t1_y", 32'(bus.y), 32'h0);
    chk("t1_valid", 32'(bus.valid), 32'h0);

    // DIRECT decode of every index
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'd1, 2'(i), 4'd0, 1'b0);
      v_exp = 4'b0001 << i;
      chk("t2_y", 32'(bus.y), 32'(v_exp));
      chk("t2_valid", 32'(bus.valid), 32'h1);
    end

    // SCAN from 2 with dwell 1, through the wrap
    step(1'b0, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 2'd2, 2'd2, 4'd1, 1'b0);
      chk("t3_y", 32'(bus.y), 32'(C_T3_Y[i]));
      chk("t3_wrap", 32'(bus.wrap), 32'(C_T3_W[i]));
    end

    // load coincides with a wrapping step: load wins
    step(1'b0, 1'b1, 2'd2, 2'd3, 4'd0, 1'b1);
    chk("t4_y3", 32'(bus.y), 32'h8);
    step(1'b0, 1'b1, 2'd2, 2'd1, 4'd0, 1'b1);
    chk("t4_yload", 32'(bus.y), 32'h2);
    chk("t4_wrap", 32'(bus.wrap), 32'h0);
    step(1'b0, 1'b1, 2'd2, 2'd1, 4'd0, 1'b0);
    chk("t4_ynext", 32'(bus.y), 32'h4);

    // en low mid-dwell, then resume from the held count
    step(1'b0, 1'b1, 2'd2, 2'd0, 4'd3, 1'b1);
    step(1'b0, 1'b1, 2'd2, 2'd0, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd2, 2'd0, 4'd3, 1'b0);
      chk("t5_y_off", 32'(bus.y), 32'h0);
      chk("t5_valid_off", 32'(bus.valid), 32'h0);
    end
    step(1'b0, 1'b1, 2'd2, 2'd0, 4'd3, 1'b0);
    chk("t5_y_res1", 32'(bus.y), 32'h1);
    step(1'b0, 1'b1, 2'd2, 2'd0, 4'd3, 1'b0);
    chk("t5_y_res2", 32'(bus.y), 32'h1);
    step(1'b0, 1'b1, 2'd2, 2'd0, 4'd3, 1'b0);
    chk("t5_y_step", 32'(bus.y), 32'h2);

    // HOLD freezes, HOLD->SCAN restarts from sel
    step(1'b0, 1'b1, 2'd3, 2'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 2'd0, 4'd0, 1'b0);
    chk("hold_y", 32'(bus.y), 32'h2);
    step(1'b0, 1'b1, 2'd2, 2'd3, 4'd0, 1'b0);
    chk("hold_restart", 32'(bus.y), 32'h8);

    // Active-low instance
    step(1'b0, 1'b1, 2'd1, 2'd2, 4'd0, 1'b0);
    chk("t6_al_y", 32'(bus_al.y), 32'hB);
    step(1'b0, 1'b1, 2'd2, 2'd1, 4'd2, 1'b0);
    step(1'b0, 1'b1, 2'd2, 2'd1, 4'd2, 1'b0);
    step(1'b1, 1'b1, 2'd2, 2'd1, 4'd2, 1'b0);
    chk("t6_al_rst_y", 32'(bus_al.y), 32'hF);
    chk("t6_al_rst_idx", 32'(bus_al.idx), 32'h0);
    chk("t6_al_rst_valid", 32'(bus_al.valid), 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step((($urandom_range(0, 39)) == 0),
           (($urandom_range(0, 7)) != 0),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)),
           (($urandom_range(0, 5)) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
